// File: rtl/tdm_demux.sv
// Purpose : TDM demultiplexer. Routes one serial sample per slot to its channel register, tracks frame sync, flags framing errors.
// Latency : a sample accepted at cycle N shows on dout, with its dout_valid bit set, at cycle N+1.
// Backpres: none. din is consumed whenever din_valid is high, and din_valid=0 cycles hold all state.
//
// Ports: clk / rst_n (async, active-low); din / din_valid / frame_sync in; sync_err_clr clears the sticky error.
//        dout packs channel c at [c*WIDTH +: WIDTH]. dout_valid is a per-channel write strobe.
//        frame_done pulses on a complete synced frame. slot is the next write index.
//        locked means the FSM is in LOCKED. sync_err is the sticky framing error.
// Option: `define TDM_DEMUX_FRAME_LATCH_EN collects samples in shadow registers, and dout
//         then updates all channels together in the frame_done cycle.
module tdm_demux #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      frame_sync,
  input  logic                      sync_err_clr,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic [CHANNELS-1:0]       dout_valid,
  output logic                      frame_done,
  output logic [SEL_W-1:0]          slot,
  output logic                      locked,
  output logic                      sync_err
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

  if (CHANNELS < 2 || (1 << SEL_W) != CHANNELS) begin : g_bad_cfg
    $error("tdm_demux: CHANNELS must be a power of two >= 2 and equal 2**SEL_W");
  end

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;
  state_t state;

  assign locked = (state == LOCKED);

  // Decode of the current input against the frame position.
  // A sync always restarts at slot 0, which covers the HUNT acquire case and the early-sync case.
  // In LOCKED, a non-sync sample at slot 0 is a missing sync: it is dropped and the FSM relocks from HUNT.
  logic             wr_en;
  logic [SEL_W-1:0] wr_idx;
  logic             wr_last;
  logic             set_err;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = slot;
    set_err = 1'b0;
    if (din_valid) begin
      if (frame_sync) begin
        wr_en   = 1'b1;
        wr_idx  = '0;
        set_err = locked && (slot != '0);
      end else if (locked) begin
        wr_en   = (slot != '0);
        set_err = (slot == '0);
      end
    end
    // In LOCKED, every frame starts from a sync at slot 0 and slots advance without skips.
    // Reaching the last slot therefore always means a complete, synced frame.
    wr_last = wr_en && (wr_idx == LAST_SLOT);
  end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
  logic [CHANNELS*WIDTH-1:0] shadow;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      slot       <= '0;
      dout       <= '0;
      dout_valid <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
`ifdef TDM_DEMUX_FRAME_LATCH_EN
      shadow     <= '0;
`endif
    end else begin
      dout_valid <= '0;
      frame_done <= wr_last;

      // A new error in the same cycle as a clear request keeps the flag set.
      if (set_err) begin
        sync_err <= 1'b1;
      end else if (sync_err_clr) begin
        sync_err <= 1'b0;
      end

      if (wr_en) begin
        dout_valid[wr_idx] <= 1'b1;
        slot               <= wr_idx + SLOT_ONE;  // the last slot wraps to 0
        state              <= LOCKED;
`ifdef TDM_DEMUX_FRAME_LATCH_EN
        shadow[wr_idx*WIDTH +: WIDTH] <= din;
        // The last channel is the top slice, so the full frame is that sample plus the shadow below it.
        if (wr_last) begin
          dout <= {din, shadow[(CHANNELS-1)*WIDTH-1:0]};
        end
`else
        dout[wr_idx*WIDTH +: WIDTH] <= din;
`endif
      end else if (set_err) begin
        state <= HUNT;
        slot  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

  localparam int WIDTH    = 1;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [WIDTH-1:0]          din;
  logic                      din_valid;
  logic                      frame_sync;
  logic                      sync_err_clr;
  logic [CHANNELS*WIDTH-1:0] dout;
  logic [CHANNELS-1:0]       dout_valid;
  logic                      frame_done;
  logic [SEL_W-1:0]          slot;
  logic                      locked;
  logic                      sync_err;

  tdm_demux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .sync_err_clr(sync_err_clr),
    .dout(dout), .dout_valid(dout_valid), .frame_done(frame_done),
    .slot(slot), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected output record for one cycle, tagged with the cycle count at which it is visible.
  typedef struct {
    logic [CHANNELS*WIDTH-1:0] dout;
    logic [CHANNELS-1:0]       dv;
    logic                      fd;
    logic [SEL_W-1:0]          slot;
    logic                      lk;
    logic                      err;
    int                        cyc;
  } exp_t;
  exp_t q[$];

  // Reference model: channel arrays plus frame position as an integer.
  logic [WIDTH-1:0] m_out [CHANNELS];
  logic [WIDTH-1:0] m_sh  [CHANNELS];
  bit               m_lk;
  bit               m_err;
  int               m_pos;

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_out[c] = '0;
      m_sh[c]  = '0;
    end
    m_lk = 0; m_err = 0; m_pos = 0;
  endtask

  task automatic model_step(input logic v, input logic fs, input logic [WIDTH-1:0] d, input logic clr);
    exp_t e;
    int   wr;
    bit   done;
    wr = -1; done = 0;
    if (clr) m_err = 0;
    if (v) begin
      if (fs) begin
        if (m_lk && m_pos != 0) m_err = 1;
        m_lk = 1; wr = 0; m_pos = 1;
      end else if (m_lk) begin
        if (m_pos == 0) begin
          m_err = 1; m_lk = 0;
        end else begin
          wr = m_pos;
          done = (m_pos == CHANNELS - 1);
          m_pos = (m_pos + 1) % CHANNELS;
        end
      end
    end
    if (wr >= 0) begin
      m_sh[wr] = d;
`ifndef TDM_DEMUX_FRAME_LATCH_EN
      m_out[wr] = d;
`endif
    end
`ifdef TDM_DEMUX_FRAME_LATCH_EN
    if (done) for (int c = 0; c < CHANNELS; c++) m_out[c] = m_sh[c];
`endif
    for (int c = 0; c < CHANNELS; c++) e.dout[c*WIDTH +: WIDTH] = m_out[c];
    e.dv   = '0;
    if (wr >= 0) e.dv[wr] = 1'b1;
    e.fd   = done;
    e.slot = SEL_W'(m_pos);
    e.lk   = m_lk;
    e.err  = m_err;
    e.cyc  = cyc + 1;
    q.push_back(e);
  endtask

  // Drive one input cycle (called at posedge+#1) and record what the DUT should show after the next edge.
  task automatic step(input logic v, input logic fs, input logic [WIDTH-1:0] d, input logic clr);
    din_valid = v; frame_sync = fs; din = d; sync_err_clr = clr;
    model_step(v, fs, d, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dout"}, 64'(dout), 64'd0);
    chk({tag, "_dv"}, 64'(dout_valid), 64'd0);
    chk({tag, "_fd"}, 64'(frame_done), 64'd0);
    chk({tag, "_slot"}, 64'(slot), 64'd0);
    chk({tag, "_locked"}, 64'(locked), 64'd0);
    chk({tag, "_err"}, 64'(sync_err), 64'd0);
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #1;
    din_valid = 0; frame_sync = 0; sync_err_clr = 0; din = '0;
    rst_n = 0;
    #1;
    check_zero(tag);
    q.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  exp_t me;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        me = q.pop_front();
        chk("dout", 64'(dout), 64'(me.dout));
        chk("dout_valid", 64'(dout_valid), 64'(me.dv));
        chk("frame_done", 64'(frame_done), 64'(me.fd));
        chk("slot", 64'(slot), 64'(me.slot));
        chk("locked", 64'(locked), 64'(me.lk));
        chk("sync_err", 64'(sync_err), 64'(me.err));
      end
    end
  end

  initial begin
    logic v, fs, clr;
    rst_n = 0; din = '0; din_valid = 0; frame_sync = 0; sync_err_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1;

    // Basic frame 1,0,1,1.
    step(1, 1, 1, 0); step(1, 0, 0, 0); step(1, 0, 1, 0); step(1, 0, 1, 0);
    chk("frame1_dout", 64'(dout), 64'b1101);
    chk("frame1_locked", 64'(locked), 64'd1);
    chk("frame1_err", 64'(sync_err), 64'd0);

    // HUNT discards unsynced samples, then locks on a sync.
    apply_reset("rst_a");
    repeat (3) step(1, 0, 1, 0);
    chk("hunt_slot", 64'(slot), 64'd0);
    chk("hunt_locked", 64'(locked), 64'd0);
    step(1, 1, 1, 0);
    chk("hunt_lock", 64'(locked), 64'd1);

    // Early sync at slot 2.
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("early_err", 64'(sync_err), 64'd1);
    chk("early_slot", 64'(slot), 64'd1);
    step(1, 0, 1, 0); step(1, 0, 0, 0); step(1, 0, 1, 0);

    // Clear together with a good sync, then finish the frame.
    step(1, 1, 1, 1); step(1, 0, 0, 0); step(1, 0, 1, 0); step(1, 0, 0, 0);

    // Missing sync at slot 0, then clear.
    step(1, 0, 1, 0);
    chk("miss_locked", 64'(locked), 64'd0);
    step(0, 0, 0, 1);
    chk("clr_err", 64'(sync_err), 64'd0);

    // A new error in the same cycle as a clear keeps the flag set.
    step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 0, 1, 0); step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("setwins_err", 64'(sync_err), 64'd1);
    step(0, 0, 0, 1);

    // Valid every third cycle across two frames.
    for (int f = 0; f < 2; f++)
      for (int s = 0; s < CHANNELS; s++) begin
        step(1, s == 0, WIDTH'($urandom), 0);
        step(0, 0, WIDTH'($urandom), 0);
        step(0, 1, WIDTH'($urandom), 0);
      end

    // Asynchronous reset after slot 2 of a frame.
    step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 0, 1, 0);
    apply_reset("rst_mid");

    // Random traffic with mostly well-formed framing.
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 9) < 7);
      if (!m_lk || m_pos == 0) fs = ($urandom_range(0, 7) != 0);
      else                     fs = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step(v, fs, WIDTH'($urandom), clr);
    end
    din_valid = 0; frame_sync = 0; sync_err_clr = 0;

    // Every queued expectation must have been consumed.
    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
